// File: rtl/receptor_serial_quadro.sv
// Serial frame receiver: start bit, NBITS_DATA data bits LSB-first, optional parity, stop bit.
// Delivers the framed word with a one-cycle valid pulse plus sticky parity/stop error flags.
module receptor_serial_quadro #(
  parameter int unsigned NBITS_DATA = 4,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  serial_in,
  output logic [NBITS_DATA-1:0] dado,
  output logic                  valido,
  output logic                  erro_paridade,
  output logic                  erro_parada,
  output logic                  ocupado,
  output logic [1:0]            estado
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [NBITS_DATA-1:0] buf_q, buf_d;
  logic [NBITS_DATA-1:0] dado_q, dado_d;
  logic                  par_q, par_d;
  logic                  valido_q, valido_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  mismatch;

  assign mismatch = PARITY_EN ? ((^buf_q ^ par_q) != PARITY_ODD) : 1'b0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    dado_d   = dado_q;
    par_d    = par_q;
    valido_d = 1'b0;
    perr_d   = perr_q;
    serr_d   = serr_q;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (!serial_in) begin
            state_d = StData;
            cnt_d   = '0;
            buf_d   = '0;
          end
        end
        StData: begin
          // Shifting in from the top lands bit k at buf[k] after NBITS_DATA samples.
          buf_d = {serial_in, buf_q[NBITS_DATA-1:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'(NBITS_DATA - 1)) begin
            state_d = PARITY_EN ? StParity : StStop;
          end
        end
        StParity: begin
          par_d   = serial_in;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (serial_in) begin
            dado_d   = buf_q;
            valido_d = 1'b1;
            perr_d   = mismatch;
            serr_d   = 1'b0;
          end else begin
            serr_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      buf_q    <= '0;
      dado_q   <= '0;
      par_q    <= 1'b0;
      valido_q <= 1'b0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      dado_q   <= dado_d;
      par_q    <= par_d;
      valido_q <= valido_d;
      perr_q   <= perr_d;
      serr_q   <= serr_d;
    end
  end

  assign dado          = dado_q;
  assign valido        = valido_q;
  assign erro_paridade = perr_q;
  assign erro_parada   = serr_q;
  assign estado        = state_q;
  assign ocupado       = (state_q != StIdle);

endmodule

// File: tb/tb_receptor_serial_quadro.sv
// Bench for receptor_serial_quadro: parity instance (A) and no-parity instance (B),
// table vectors, directed corner sequences and randomized frames vs a frame-level model.
module tb_receptor_serial_quadro;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       en_a, sin_a, en_b, sin_b;
  logic [3:0] dado_a, dado_b;
  logic       valido_a, perr_a, serr_a, ocup_a;
  logic       valido_b, perr_b, serr_b, ocup_b;
  logic [1:0] estado_a, estado_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit sel_b    = 1'b0;

  always #5 clk_2 = ~clk_2;

  receptor_serial_quadro #(.NBITS_DATA(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_a (
    .clk_2(clk_2), .reset(reset), .enable(en_a), .serial_in(sin_a), .dado(dado_a),
    .valido(valido_a), .erro_paridade(perr_a), .erro_parada(serr_a), .ocupado(ocup_a),
    .estado(estado_a)
  );

  receptor_serial_quadro #(.NBITS_DATA(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_b (
    .clk_2(clk_2), .reset(reset), .enable(en_b), .serial_in(sin_b), .dado(dado_b),
    .valido(valido_b), .erro_paridade(perr_b), .erro_parada(serr_b), .ocupado(ocup_b),
    .estado(estado_b)
  );

  typedef struct {
    logic [3:0] data;
    logic       par;
    logic       stop;
    logic [3:0] exp_dado;
    logic       exp_valid;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle to the selected instance; returns 1 time unit after the edge.
  task automatic tick(input logic en, input logic b);
    if (sel_b) begin
      en_b = en; sin_b = b; en_a = 1'b0; sin_a = 1'b1;
    end else begin
      en_a = en; sin_a = b; en_b = 1'b0; sin_b = 1'b1;
    end
    @(posedge clk_2);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] data, input logic par, input logic stop,
                            input int max_gap);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 4; i++) bits.push_back(data[i]);
    if (!sel_b) bits.push_back(par);
    bits.push_back(stop);
    foreach (bits[k]) begin
      repeat ($urandom_range(0, max_gap)) tick(1'b0, 1'($urandom_range(0, 1)));
      tick(1'b1, bits[k]);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] d, input logic v,
                           input logic pe, input logic se);
    if (sel_b) begin
      check({name, " dado"}, 32'(dado_b), 32'(d));
      check({name, " valido"}, 32'(valido_b), 32'(v));
      check({name, " erro_paridade"}, 32'(perr_b), 32'(pe));
      check({name, " erro_parada"}, 32'(serr_b), 32'(se));
    end else begin
      check({name, " dado"}, 32'(dado_a), 32'(d));
      check({name, " valido"}, 32'(valido_a), 32'(v));
      check({name, " erro_paridade"}, 32'(perr_a), 32'(pe));
      check({name, " erro_parada"}, 32'(serr_a), 32'(se));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic       t1[7];
    logic [3:0] m_dado;
    logic       m_perr, m_serr;
    logic [3:0] d;
    logic       p, s;

    vecs[0] = '{4'hD, 1'b0, 1'b1, 4'hD, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{4'h6, 1'b0, 1'b0, 4'hD, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{4'h6, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'hA, 1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{4'h7, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'h3, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; en_a = 1'b0; sin_a = 1'b1; en_b = 1'b0; sin_b = 1'b1;
    repeat (2) @(posedge clk_2);
    #1 reset = 1'b0;
    check_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    check("reset estado", 32'(estado_a), 32'd0);
    check("reset ocupado", 32'(ocup_a), 32'd0);

    // Frame 4'hD with correct even parity, tracking estado.
    tick(1'b1, 1'b0);
    check("t1 estado start", 32'(estado_a), 32'd1);
    check("t1 ocupado", 32'(ocup_a), 32'd1);
    tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    check("t1 estado data", 32'(estado_a), 32'd1);
    tick(1'b1, 1'b1);
    check("t1 estado parity", 32'(estado_a), 32'd2);
    tick(1'b1, 1'b1);
    check("t1 estado stop", 32'(estado_a), 32'd3);
    check("t1 no early valido", 32'(valido_a), 32'd0);
    tick(1'b1, 1'b1);
    check("t1 estado idle", 32'(estado_a), 32'd0);
    check_out("t1", 4'hD, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("t1 valido drop", 32'(valido_a), 32'd0);

    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 0);
      check_out($sformatf("vec%0d", i), vecs[i].exp_dado, vecs[i].exp_valid,
                vecs[i].exp_perr, vecs[i].exp_serr);
      tick(1'b0, 1'b1);
      check($sformatf("vec%0d valido drop", i), 32'(valido_a), 32'd0);
    end

    // Asynchronous reset mid-DATA.
    tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b0);
    #3 reset = 1'b1;
    #1;
    check("async reset estado", 32'(estado_a), 32'd0);
    check("async reset ocupado", 32'(ocup_a), 32'd0);
    check_out("async reset", 4'h0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    send_frame(4'h6, 1'b0, 1'b1, 0);
    check_out("post reset", 4'h6, 1'b1, 1'b0, 1'b0);

    // Enable one cycle in three, line held for three cycles per bit.
    t1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    foreach (t1[k]) begin
      tick(1'b1, t1[k]);
      if (k == 6) check_out("slow enable", 4'hD, 1'b1, 1'b0, 1'b0);
      tick(1'b0, t1[k]);
      if (k == 6) check("slow enable valido drop", 32'(valido_a), 32'd0);
      tick(1'b0, t1[k]);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1);
      check("idle estado", 32'(estado_a), 32'd0);
      check("idle ocupado", 32'(ocup_a), 32'd0);
    end

    // No-parity instance skips the parity state.
    sel_b = 1'b1;
    tick(1'b1, 1'b0);
    check("b estado start", 32'(estado_b), 32'd1);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    check("b estado data", 32'(estado_b), 32'd1);
    tick(1'b1, 1'b0);
    check("b estado stop", 32'(estado_b), 32'd3);
    tick(1'b1, 1'b1);
    check("b estado idle", 32'(estado_b), 32'd0);
    check_out("b frame", 4'h4, 1'b1, 1'b0, 1'b0);

    // Randomized frames against a frame-level model.
    reset = 1'b1;
    #3 reset = 1'b0;
    for (int inst = 0; inst < 2; inst++) begin
      sel_b  = (inst == 1);
      m_dado = 4'h0; m_perr = 1'b0; m_serr = 1'b0;
      for (int n = 0; n < 40; n++) begin
        d = 4'($urandom_range(0, 15));
        p = 1'($urandom_range(0, 1));
        s = ($urandom_range(0, 3) != 0);
        repeat ($urandom_range(0, 2)) tick(1'b1, 1'b1);
        send_frame(d, p, s, 2);
        if (s) begin
          m_dado = d;
          m_perr = sel_b ? 1'b0 : ((^d) ^ p);
          m_serr = 1'b0;
        end else begin
          m_serr = 1'b1;
        end
        check_out($sformatf("rand i%0d n%0d", inst, n), m_dado, s, m_perr, m_serr);
        tick(1'($urandom_range(0, 1)), 1'b1);
        check($sformatf("rand i%0d n%0d valido drop", inst, n),
              32'(sel_b ? valido_b : valido_a), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
